// File: rtl/maxbw_pkg.sv
// Shared types and constants for the DDR frame sink: parser state, statistic
// select codes and the default frame start marker.
package maxbw_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LEN_S   = 2'd1,
        PAYLOAD = 2'd2,
        CHECK   = 2'd3
    } state_t;

    typedef struct packed {
        state_t      st;
        logic [15:0] rem;
        logic [15:0] sum;
    } fsm_t;

    localparam logic [1:0] SEL_OK    = 2'd0;
    localparam logic [1:0] SEL_ERR   = 2'd1;
    localparam logic [1:0] SEL_SUM   = 2'd2;
    localparam logic [1:0] SEL_STATE = 2'd3;

    localparam logic [15:0] DEF_SYNC_WORD = 16'hA55A;

endpackage

// File: rtl/frame_word_step.sv
// One word of the frame parser: pure combinational next-state, chained twice
// per cycle by the top so both DDR lanes are consumed in one clock.
module frame_word_step
    import maxbw_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD = DEF_SYNC_WORD,
    parameter int          MAX_LEN   = 255
) (
    input  fsm_t        cur,
    input  logic [15:0] word,
    output fsm_t        nxt,
    output logic        ok,
    output logic        err
);

    localparam logic [16:0] MAX_LEN_W = 17'(MAX_LEN);

    always_comb begin
        nxt = cur;
        ok  = 1'b0;
        err = 1'b0;
        case (cur.st)
            HUNT: begin
                if (word == SYNC_WORD) nxt.st = LEN_S;
            end
            LEN_S: begin
                if (word == 16'd0 || {1'b0, word} > MAX_LEN_W) begin
                    err    = 1'b1;
                    nxt.st = HUNT;
                end else begin
                    nxt.rem = word;
                    nxt.sum = 16'd0;
                    nxt.st  = PAYLOAD;
                end
            end
            PAYLOAD: begin
                nxt.sum = cur.sum + word;
                nxt.rem = cur.rem - 16'd1;
                // rem is always >= 1 here because LEN 0 never reaches PAYLOAD
                if (cur.rem == 16'd1) nxt.st = CHECK;
            end
            default: begin
                if (word == cur.sum) ok = 1'b1;
                else                 err = 1'b1;
                nxt.st = HUNT;
            end
        endcase
    end

endmodule

// File: rtl/ddr_frame_sink.sv
// Framed word-stream consumer behind the DDR capture stage: parses lo then hi
// word each enabled cycle, pulses good/bad frame and keeps saturating stats.
module ddr_frame_sink
    import maxbw_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD = DEF_SYNC_WORD,
    parameter int          MAX_LEN   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_lo,
    input  logic [15:0] in_hi,
    input  logic [1:0]  sel,
    output logic [7:0]  stat_out,
    output logic        frame_ok,
    output logic        frame_err,
    output logic        locked
);

    fsm_t        cur_q;
    fsm_t        mid, fin;
    logic        ok_lo, err_lo, ok_hi, err_hi;
    logic        ok_ev, err_ev;
    logic [7:0]  ok_cnt, err_cnt;
    logic [15:0] last_sum;

    frame_word_step #(.SYNC_WORD(SYNC_WORD), .MAX_LEN(MAX_LEN)) u_step_lo (
        .cur(cur_q), .word(in_lo), .nxt(mid), .ok(ok_lo), .err(err_lo)
    );

    frame_word_step #(.SYNC_WORD(SYNC_WORD), .MAX_LEN(MAX_LEN)) u_step_hi (
        .cur(mid), .word(in_hi), .nxt(fin), .ok(ok_hi), .err(err_hi)
    );

    // A frame is at least 4 words, so only one lane can terminate per cycle
    assign ok_ev  = in_valid & (ok_lo | ok_hi);
    assign err_ev = in_valid & (err_lo | err_hi);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q     <= '{st: HUNT, rem: 16'd0, sum: 16'd0};
            ok_cnt    <= 8'd0;
            err_cnt   <= 8'd0;
            last_sum  <= 16'd0;
            stat_out  <= 8'd0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            locked    <= 1'b0;
        end else begin
            frame_ok  <= ok_ev;
            frame_err <= err_ev;
            if (in_valid) begin
                cur_q  <= fin;
                locked <= (fin.st != HUNT);
            end else begin
                locked <= (cur_q.st != HUNT);
            end
            if (ok_ev && ok_cnt != 8'hFF)   ok_cnt  <= ok_cnt + 8'd1;
            if (err_ev && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            if (ok_ev) last_sum <= ok_lo ? in_lo : in_hi;
            case (sel)
                SEL_OK:  stat_out <= ok_cnt;
                SEL_ERR: stat_out <= err_cnt;
                SEL_SUM: stat_out <= last_sum[7:0];
                default: stat_out <= {locked, cur_q.st, 5'b0};
            endcase
        end
    end

endmodule
